// File: rtl/circulant_pkg.sv
// Shared definitions for the C(16; 2, 3) circulant router and the blocks
// that feed it.
//   K          - width of a router/node number
//   N2         - packet width (valid bit + payload)
//   NODE_COUNT - number of routers in the circulant
//   VALID_BIT  - index of the packet valid bit
//   build_packet()    - forms {1, zeros, dest}
//   dest_is_invalid() - true for out-of-range or self-addressed destinations
//   inj_state_e       - injection FSM states
package circulant_pkg;

    localparam int K          = 5;
    localparam int N2         = 11;
    localparam int NODE_COUNT = 16;
    localparam int VALID_BIT  = N2 - 1;

    // NODE_COUNT as a K+1 bit vector so range checks compare like with like
    localparam logic [K:0] NODE_COUNT_W = (K + 1)'(NODE_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } inj_state_e;

    function automatic logic [N2-1:0] build_packet(input logic [K-1:0] dest);
        build_packet = {1'b1, {(N2 - 1 - K){1'b0}}, dest};
    endfunction

    function automatic logic dest_is_invalid(input logic [K-1:0] dest,
                                             input logic [K-1:0] self_name);
        dest_is_invalid = ({1'b0, dest} >= NODE_COUNT_W) || (dest == self_name);
    endfunction

endpackage

// File: rtl/inject_fifo.sv
// Small synchronous FIFO with an explicit occupancy count.
//   clk, rst_n   - clock, asynchronous active-low reset
//   push, push_data - write one entry (caller guarantees not full)
//   pop          - discard the head entry (caller guarantees not empty)
//   head         - current head entry, valid whenever empty = 0
//   count        - occupancy, 0..DEPTH
//   empty, full  - decoded from the registered count
module inject_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    // Storage carries no reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));

endmodule

// File: rtl/circulant_inject_queue.sv
// Injection stage between an IP core and the in_free port of a circulant
// router. Requests are queued, filtered against the local router number,
// and injected as single-cycle packets only while all four inbound links
// are idle. A transit packet arriving during the send cycle is flagged.
//   clk, rst_n          - clock, asynchronous active-low reset
//   router_name         - number of the attached router (static)
//   req_valid/req_dest  - request from IP core; req_ready = queue not full
//   link_r1R..link_r2L  - copies of the router's link inputs (monitor only)
//   out_free            - registered packet to router in_free
//   reject              - 1-cycle pulse: request discarded
//   collision           - 1-cycle pulse: injection overlapped a transit packet
//   fifo_count          - queue occupancy
module circulant_inject_queue
    import circulant_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int HOLDOFF = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [K-1:0]           router_name,
    input  logic                   req_valid,
    input  logic [K-1:0]           req_dest,
    output logic                   req_ready,
    input  logic [N2-1:0]          link_r1R,
    input  logic [N2-1:0]          link_r2R,
    input  logic [N2-1:0]          link_r1L,
    input  logic [N2-1:0]          link_r2L,
    output logic [N2-1:0]          out_free,
    output logic                   reject,
    output logic                   collision,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int GCW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [GCW-1:0] GAP_LOAD = (HOLDOFF > 1) ? GCW'(HOLDOFF - 1) : '0;

    // Link monitor: only the valid bits matter.
    logic [N2-1:0] links [4];
    logic [3:0]    link_valid;
    logic          links_idle;
    logic          unused_link_payload;

    assign links[0] = link_r1R;
    assign links[1] = link_r2R;
    assign links[2] = link_r1L;
    assign links[3] = link_r2L;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_link_valid
            assign link_valid[gi] = links[gi][VALID_BIT];
        end
    endgenerate

    assign links_idle = ~|link_valid;
    assign unused_link_payload = ^{link_r1R[N2-2:0], link_r2R[N2-2:0],
                                   link_r1L[N2-2:0], link_r2L[N2-2:0]};

    // Request acceptance and filtering
    logic          fifo_full;
    logic          fifo_empty;
    logic [K-1:0]  fifo_head;
    logic          accept;
    logic          dest_bad;
    logic          push;
    logic          pop;

    assign req_ready = ~fifo_full;
    assign accept    = req_valid && req_ready;
    assign dest_bad  = dest_is_invalid(req_dest, router_name);
    assign push      = accept && !dest_bad;

    inject_fifo #(
        .WIDTH (K),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (req_dest),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Injection FSM
    inj_state_e     state_reg, state_next;
    logic [N2-1:0]  out_free_reg, out_free_next;
    logic [GCW-1:0] gap_reg, gap_next;
    logic           collision_reg, collision_next;
    logic           reject_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            out_free_reg  <= '0;
            gap_reg       <= '0;
            collision_reg <= 1'b0;
            reject_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_free_reg  <= out_free_next;
            gap_reg       <= gap_next;
            collision_reg <= collision_next;
            reject_reg    <= accept && dest_bad;
        end
    end

    always_comb begin
        state_next     = state_reg;
        out_free_next  = out_free_reg;
        gap_next       = gap_reg;
        collision_next = 1'b0;
        pop            = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty && links_idle) begin
                    out_free_next = build_packet(fifo_head);
                    pop           = 1'b1;
                    state_next    = ST_SEND;
                end
            end
            ST_SEND: begin
                // The router favours in_free, so any transit packet seen now
                // is lost; report it and carry on without retrying.
                collision_next = ~links_idle;
                out_free_next  = '0;
                if (HOLDOFF > 0) begin
                    gap_next   = GAP_LOAD;
                    state_next = ST_GAP;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_next = gap_reg - 1'b1;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                out_free_next = '0;
            end
        endcase
    end

    assign out_free  = out_free_reg;
    assign reject    = reject_reg;
    assign collision = collision_reg;

endmodule

// File: tb/tb_circulant_inject_queue.sv
module tb_circulant_inject_queue;

    localparam int DEPTH   = 4;
    localparam int HOLDOFF = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  router_name;
    logic        req_valid;
    logic [4:0]  req_dest;
    logic        req_ready;
    logic [10:0] link_r1R, link_r2R, link_r1L, link_r2L;
    logic [10:0] out_free;
    logic        reject;
    logic        collision;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    circulant_inject_queue #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .router_name (router_name),
        .req_valid   (req_valid),
        .req_dest    (req_dest),
        .req_ready   (req_ready),
        .link_r1R    (link_r1R),
        .link_r2R    (link_r2R),
        .link_r1L    (link_r1L),
        .link_r2L    (link_r2L),
        .out_free    (out_free),
        .reject      (reject),
        .collision   (collision),
        .fifo_count  (fifo_count)
    );

    // Scoreboard state
    typedef struct {
        int          cyc;
        logic [10:0] pkt;
    } exp_pkt_t;

    exp_pkt_t   exp_out[$];
    int         exp_rej[$];
    int         exp_col[$];
    logic [4:0] mq[$];          // reference queue of pending destinations
    int         exp_count = 0;
    int         last_inj  = -100;
    int         cyc       = 0;
    int         checks    = 0;
    int         passes    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        mq.delete();
        exp_out.delete();
        exp_rej.delete();
        exp_col.delete();
        exp_count = 0;
        last_inj  = -100;
    endtask

    // Reference model: evaluated once per rising edge from the inputs held
    // during the cycle that just ended.
    // - injection needs a queued entry, idle links, and HOLDOFF+2 edges since
    //   the previous injection (send cycle, holdoff cycles, one idle cycle)
    // - a link valid during the send cycle yields a collision report
    // - readiness uses the occupancy before this edge
    initial begin
        bit       busy;
        int       pre;
        exp_pkt_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                clear_model();
            end else begin
                busy = link_r1R[10] | link_r2R[10] | link_r1L[10] | link_r2L[10];
                pre  = mq.size();
                if (cyc == last_inj + 1 && busy) exp_col.push_back(cyc);
                if (pre > 0 && !busy && (cyc - last_inj) >= HOLDOFF + 2) begin
                    e.cyc = cyc;
                    e.pkt = {1'b1, 5'b00000, mq[0]};
                    exp_out.push_back(e);
                    void'(mq.pop_front());
                    last_inj = cyc;
                end
                if (req_valid && pre < DEPTH) begin
                    if (req_dest >= 5'd16 || req_dest == router_name)
                        exp_rej.push_back(cyc);
                    else
                        mq.push_back(req_dest);
                end
                exp_count = mq.size();
            end
        end
    end

    // Monitor: samples on the falling edge and retires expectations.
    initial begin
        exp_pkt_t e;
        int       c;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("fifo_count", 32'(fifo_count), 32'(exp_count));
                check("req_ready", 32'(req_ready), 32'(exp_count < DEPTH));
                while (exp_out.size() > 0 && exp_out[0].cyc < cyc) begin
                    e = exp_out.pop_front();
                    check("out_missing", 32'(cyc), 32'(e.cyc));
                end
                while (exp_rej.size() > 0 && exp_rej[0] < cyc) begin
                    c = exp_rej.pop_front();
                    check("reject_missing", 32'(cyc), 32'(c));
                end
                while (exp_col.size() > 0 && exp_col[0] < cyc) begin
                    c = exp_col.pop_front();
                    check("collision_missing", 32'(cyc), 32'(c));
                end
                if (out_free !== 11'd0) begin
                    if (exp_out.size() == 0) begin
                        check("out_unexpected", 32'(out_free), 32'd0);
                    end else begin
                        e = exp_out.pop_front();
                        check("out_pkt", 32'(out_free), 32'(e.pkt));
                        check("out_cycle", 32'(cyc), 32'(e.cyc));
                        $display("cycle %0d: injected 0x%03h", cyc, out_free);
                    end
                end
                if (reject !== 1'b0) begin
                    if (exp_rej.size() == 0) begin
                        check("reject_unexpected", 32'(reject), 32'd0);
                    end else begin
                        c = exp_rej.pop_front();
                        check("reject_cycle", 32'(cyc), 32'(c));
                        $display("cycle %0d: reject", cyc);
                    end
                end
                if (collision !== 1'b0) begin
                    if (exp_col.size() == 0) begin
                        check("collision_unexpected", 32'(collision), 32'd0);
                    end else begin
                        c = exp_col.pop_front();
                        check("collision_cycle", 32'(cyc), 32'(c));
                        $display("cycle %0d: collision", cyc);
                    end
                end
            end
        end
    end

    // Stimulus: inputs change 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [4:0] d);
        req_valid = v;
        req_dest  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic links_off();
        link_r1R = '0; link_r2R = '0; link_r1L = '0; link_r2L = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0);
    endtask

    function automatic logic [10:0] rand_link();
        logic [9:0] payload;
        payload = 10'($urandom);
        return {($urandom_range(0, 4) == 0), payload};
    endfunction

    initial begin
        bit found;
        rst_n       = 1'b0;
        router_name = 5'd0;
        req_valid   = 1'b0;
        req_dest    = 5'd0;
        links_off();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_free", 32'(out_free), 32'd0);
        check("rst_reject", 32'(reject), 32'd0);
        check("rst_collision", 32'(collision), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        #1 rst_n = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // Single injection: router 0, dest 5
        step(1'b1, 5'd5);
        step(1'b0, 5'd0);
        check("single_pkt", 32'(out_free), 32'(11'b10000000101));
        step(1'b0, 5'd0);
        check("single_len", 32'(out_free), 32'd0);
        idle(4);

        // Rejects: router 7, dest 7 and dest 16
        router_name = 5'd7;
        step(1'b1, 5'd7);
        step(1'b1, 5'd16);
        check("rej_count", 32'(fifo_count), 32'd0);
        idle(4);

        // Full and backpressure with link_r1R busy
        router_name = 5'd0;
        link_r1R = 11'h40A;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check("full_ready", 32'(req_ready), 32'd0);
            step(1'b1, 5'(i + 1));
        end
        links_off();
        idle(16);

        // Link busy for 10 cycles with one entry queued
        link_r2L = 11'b10000100001;
        step(1'b1, 5'd3);
        idle(9);
        links_off();
        idle(6);

        // Simultaneous push and pop at count 2, then collisions
        link_r1L = 11'h401;
        step(1'b1, 5'd2);
        step(1'b1, 5'd4);
        links_off();
        step(1'b1, 5'd6);
        check("pushpop_count", 32'(fifo_count), 32'd2);
        for (int i = 0; i < 12; i++) begin
            link_r1L = out_free[10] ? 11'h401 : 11'h000;
            step(1'b0, 5'd0);
        end
        links_off();
        idle(4);

        // Reset while in SEND with 3 entries queued
        link_r2R = 11'h7FF;
        for (int i = 0; i < 4; i++) step(1'b1, 5'(8 + i));
        links_off();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (out_free[10]) found = 1'b1;
            else step(1'b0, 5'd0);
        end
        check("midsend_reached", 32'(found), 32'd1);
        check("midsend_count", 32'(fifo_count), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        clear_model();
        check("midsend_out_free", 32'(out_free), 32'd0);
        check("midsend_fifo_count", 32'(fifo_count), 32'd0);
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("midsend_req_ready", 32'(req_ready), 32'd1);
        check("midsend_fifo_after", 32'(fifo_count), 32'd0);
        @(posedge clk); #1;
        idle(3);

        // Randomized traffic
        router_name = 5'd9;
        for (int i = 0; i < 800; i++) begin
            link_r1R = rand_link();
            link_r2R = rand_link();
            link_r1L = rand_link();
            link_r2L = rand_link();
            if ($urandom_range(0, 7) == 0)
                step(1'($urandom), router_name);
            else
                step(1'($urandom), 5'($urandom_range(0, 19)));
        end
        links_off();
        idle(30);

        check("drain_out", 32'(exp_out.size()), 32'd0);
        check("drain_rej", 32'(exp_rej.size()), 32'd0);
        check("drain_col", 32'(exp_col.size()), 32'd0);
        check("drain_count", 32'(fifo_count), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/circulant_inject_queue.md
# circulant_inject_queue

Injection stage between a compute node (IP core) and the `in_free` port of a circulant router for C(16; 2, 3), d=2. It accepts destination requests over a valid/ready handshake and buffers them in a small FIFO. It checks them against the local router number and emits one single-cycle packet on `in_free` only when every inter-router link into the router is idle. Collisions with in-flight transit packets are flagged for debug and verification.

## Interface
- `K`, 5, width of node numbers
- `N2`, 11, packet width: valid bit plus payload
- `NODE_COUNT`, 16, number of routers in the circulant
- `DEPTH`, 4, FIFO entries (power of two)
- `HOLDOFF`, 1, idle cycles forced after each injection (≥0)
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `router_name` in K: number of the attached router, static
- `req_valid` in 1: IP core request present
- `req_dest` in K: destination router number
- `req_ready` out 1: queue can accept
- `link_r1R`, `link_r2R`, `link_r1L`, `link_r2L` in N2 each: copies of the router's four link inputs (monitor only)
- `out_free` out N2: packet to router `in_free`
- `reject` out 1: one-cycle pulse, request discarded
- `collision` out 1: one-cycle pulse, injected packet coincided with a transit packet
- `fifo_count` out $clog2(DEPTH)+1: current occupancy

## Operation
- Packet format: `{1'b1, (N2-1-K)'b0, dest}`. A packet is valid iff bit N2-1 = 1. `out_free` = 0 when idle.
- Accept rule: a request is accepted when `req_valid && req_ready`. `req_ready` = (`fifo_count` < DEPTH), decoded from registered state only.
- Rejection: an accepted request with `req_dest` ≥ NODE_COUNT, or `req_dest` == `router_name`, is not written to the FIFO. `reject` pulses on the following cycle.
- `links_idle` = bit N2-1 of all four `link_*` inputs equal to 0. It is sampled in the current cycle.
- FSM states:
  - IDLE: if the FIFO is non-empty and `links_idle`, register the head packet into `out_free` and pop. Go to SEND.
  - SEND: `out_free` holds the packet for exactly this one cycle. If any `link_*` valid bit = 1 in this cycle, pulse `collision` next cycle. The router gives `in_free` priority, so this is a lost transit packet. No retry is made. Next state is GAP if HOLDOFF > 0, else IDLE. `out_free` is cleared at the exit edge.
  - GAP: a counter loads HOLDOFF-1 and decrements. Go to IDLE at 0. `out_free` = 0.
- Simultaneous push and pop: both are performed and the count is unchanged. Push while full is impossible because `req_ready` = 0.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. The count is kept separately so full and empty are unambiguous.
- Reset (asynchronous, any state, including mid-SEND):
  - FSM returns to IDLE; pointers, count and GAP counter are cleared.
  - `out_free`=0, `reject`=0, `collision`=0, `fifo_count`=0.
  - `req_ready`=1 after deassertion.
  - A packet in flight is truncated; queued entries are lost.

## Timing
- Minimum latency: a request accepted at edge E0 appears on `out_free` after E1, provided links are idle in the cycle between E0 and E1.
- Back-to-back injections with HOLDOFF=1 occur at most once every 3 cycles (SEND, GAP, IDLE).
- `out_free` is driven directly from a register. It has no combinational path from `link_*` or `req_*`.
- `reject` and `collision` are registered, one cycle wide.

## Structure
- A shared package `circulant_pkg` holds K, N2, NODE_COUNT, the valid-bit index, the packet-build function and the FSM state enum. The router uses the same package.
- Sub-module `inject_fifo` (synchronous FIFO with count, push/pop, head output). The FSM and link monitor live in the top level.

## Test plan
1. Reset mid-operation:
   - Stimulus: assert `rst_n`=0 while in SEND with 3 entries queued.
   - Response: `out_free`=0 immediately, `fifo_count`=0, `req_ready`=1 after release.
2. Single injection:
   - Stimulus: `router_name`=0, `req_dest`=5, links idle.
   - Response: `out_free`=11'b10000000101 for exactly one cycle, 2 edges after acceptance.
3. Reject:
   - Stimulus: `router_name`=7, requests dest=7 and dest=16.
   - Response: two `reject` pulses, `fifo_count` stays 0, `out_free` stays 0.
4. Full and backpressure:
   - Stimulus: hold `link_r1R` valid and push 5 requests.
   - Response: 4 accepted, `req_ready`=0 on the 5th. After release, 4 packets drain in FIFO order, 3 cycles apart.
5. Link busy:
   - Stimulus: `link_r2L`=11'b10000100001 for 10 cycles with 1 entry queued.
   - Response: no injection during those cycles; injection on the first idle cycle.
6. Collision:
   - Stimulus: a link turns valid in the SEND cycle.
   - Response: `collision` pulses once and the FIFO entry is consumed. Also check that a simultaneous push and pop at count=2 leaves `fifo_count`=2.
